// File: rtl/xadc_drp_arbiter.sv
// rtl/xadc_drp_arbiter.sv - two-requester round-robin arbiter for the XADC DRP port.
// Optional transaction timeout is built when XADC_DRP_ARB_TIMEOUT_EN is defined.
module xadc_drp_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        xadc_dclk,
  input  logic        xadc_reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_we,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [6:0]  xadc_daddr,
  output logic        xadc_den,
  output logic        xadc_dwe,
  output logic [15:0] xadc_di,
  input  logic [15:0] xadc_do,
  input  logic        xadc_drdy
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        busy_q, busy_d;
  logic        den_q, den_d;
  logic        dwe_q, dwe_d;
  logic [6:0]  daddr_q, daddr_d;
  logic [15:0] di_q, di_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        win;

`ifdef XADC_DRP_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        tmo_hit;

  // Expiry is flagged on the edge that would bring the count to TIMEOUT_CYCLES.
  assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

  // last_q holds the index granted most recently; a tie goes to the other one.
  assign win = req[1] & (~req[0] | ~last_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = 2'b00;
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    busy_d      = busy_q;
    den_d       = 1'b0;
    dwe_d       = dwe_q;
    daddr_d     = daddr_q;
    di_d        = di_q;
    owner_d     = owner_q;
    last_d      = last_q;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (|req) begin
          gnt_d   = {win, ~win};
          den_d   = 1'b1;
          dwe_d   = win ? req_we[1] : req_we[0];
          daddr_d = win ? req_addr[13:7] : req_addr[6:0];
          di_d    = win ? req_wdata[31:16] : req_wdata[15:0];
          busy_d  = 1'b1;
          owner_d = win;
          last_d  = win;
          state_d = WAIT;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
          tmo_cnt_d = 16'd0;
`endif
        end
      end
      WAIT: begin
        if (xadc_drdy) begin
          rsp_valid_d = {owner_q, ~owner_q};
          rsp_data_d  = xadc_do;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
`ifdef XADC_DRP_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_valid_d = {owner_q, ~owner_q};
          rsp_data_d  = 16'hFFFF;
          rsp_err_d   = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge xadc_dclk) begin
    if (xadc_reset) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= 7'h00;
      di_q        <= 16'h0000;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
      tmo_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      den_q       <= den_d;
      dwe_q       <= dwe_d;
      daddr_q     <= daddr_d;
      di_q        <= di_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
`ifdef XADC_DRP_ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign xadc_daddr = daddr_q;
  assign xadc_den   = den_q;
  assign xadc_dwe   = dwe_q;
  assign xadc_di    = di_q;

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// tb/tb_xadc_drp_arbiter.sv - directed self-checking bench for xadc_drp_arbiter.
module tb_xadc_drp_arbiter;

  logic        clk = 1'b0;
  logic        xadc_reset;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [6:0]  xadc_daddr;
  logic        xadc_den;
  logic        xadc_dwe;
  logic [15:0] xadc_di;
  logic [15:0] xadc_do;
  logic        xadc_drdy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xadc_drp_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .xadc_dclk (clk),
    .xadc_reset(xadc_reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .xadc_daddr(xadc_daddr),
    .xadc_den  (xadc_den),
    .xadc_dwe  (xadc_dwe),
    .xadc_di   (xadc_di),
    .xadc_do   (xadc_do),
    .xadc_drdy (xadc_drdy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] tie_order [4];
    tie_order[0] = 2'b01; tie_order[1] = 2'b10;
    tie_order[2] = 2'b01; tie_order[3] = 2'b10;

    xadc_reset = 1'b1; req = 2'b00; req_we = 2'b00; req_addr = 14'h0;
    req_wdata = 32'h0; xadc_do = 16'h0; xadc_drdy = 1'b0;
    step(); step();
    xadc_reset = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_den", 32'(xadc_den), 32'h0);
    chk("rst_daddr", 32'(xadc_daddr), 32'h0);
    chk("rst_di", 32'(xadc_di), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    step();
    chk("idle_busy", 32'(busy), 32'h0);

    // Tie: both requesters held high for four transactions.
    req = 2'b11; req_addr = {7'h20, 7'h10};
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("tie%0d_gnt", i), 32'(gnt), 32'(tie_order[i]));
      chk($sformatf("tie%0d_daddr", i), 32'(xadc_daddr), tie_order[i][1] ? 32'h20 : 32'h10);
      step();
      chk($sformatf("tie%0d_gnt_busy", i), 32'(gnt), 32'h0);
      xadc_drdy = 1'b1; xadc_do = 16'(16'h100 + i);
      step();
      xadc_drdy = 1'b0;
      chk($sformatf("tie%0d_rsp", i), 32'(rsp_valid), 32'(tie_order[i]));
      chk($sformatf("tie%0d_gnt_rsp", i), 32'(gnt), 32'h0);
      chk($sformatf("tie%0d_data", i), 32'(rsp_data), 32'h100 + i);
    end
    req = 2'b00;

    // Sampler read of 7'h03, drdy four cycles after den.
    req = 2'b01; req_we = 2'b00; req_addr = {7'h55, 7'h03};
    step();
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_den", 32'(xadc_den), 32'h1);
    chk("rd_dwe", 32'(xadc_dwe), 32'h0);
    chk("rd_daddr", 32'(xadc_daddr), 32'h03);
    chk("rd_busy", 32'(busy), 32'h1);
    req = 2'b00;
    step();
    chk("rd_gnt_clr", 32'(gnt), 32'h0);
    chk("rd_den_clr", 32'(xadc_den), 32'h0);
    step(); step(); step();
    xadc_drdy = 1'b1; xadc_do = 16'h1234;
    chk("rd_no_early_rsp", 32'(rsp_valid), 32'h0);
    step();
    xadc_drdy = 1'b0; xadc_do = 16'h0;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_data", 32'(rsp_data), 32'h1234);
    chk("rd_rsp_err", 32'(rsp_err), 32'h0);
    chk("rd_busy_clr", 32'(busy), 32'h0);
    step();
    chk("rd_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("rd_data_hold", 32'(rsp_data), 32'h1234);

    // Stray drdy in IDLE.
    xadc_drdy = 1'b1; xadc_do = 16'hDEAD;
    step();
    xadc_drdy = 1'b0;
    chk("idle_drdy_rsp", 32'(rsp_valid), 32'h0);
    chk("idle_drdy_data", 32'(rsp_data), 32'h1234);

    // Config writer write of 16'hA5A5 to 7'h41.
    req = 2'b10; req_we = 2'b11; req_addr = {7'h41, 7'h7F}; req_wdata = {16'hA5A5, 16'h1111};
    step();
    chk("wr_gnt", 32'(gnt), 32'h2);
    chk("wr_den", 32'(xadc_den), 32'h1);
    chk("wr_dwe", 32'(xadc_dwe), 32'h1);
    chk("wr_daddr", 32'(xadc_daddr), 32'h41);
    chk("wr_di", 32'(xadc_di), 32'hA5A5);
    req = 2'b00; req_we = 2'b00; req_addr = 14'h3FFF; req_wdata = 32'h0;
    step();
    chk("wr_daddr_hold", 32'(xadc_daddr), 32'h41);
    chk("wr_di_hold", 32'(xadc_di), 32'hA5A5);
    chk("wr_dwe_hold", 32'(xadc_dwe), 32'h1);
    xadc_drdy = 1'b1; xadc_do = 16'h0042;
    step();
    xadc_drdy = 1'b0;
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("wr_rsp_data", 32'(rsp_data), 32'h0042);

    // drdy and a new r1 request in the same cycle.
    req = 2'b01; req_addr = {7'h22, 7'h05};
    step();
    chk("ovl_gnt0", 32'(gnt), 32'h1);
    req = 2'b00;
    step();
    xadc_drdy = 1'b1; xadc_do = 16'h7777; req = 2'b10;
    step();
    xadc_drdy = 1'b0;
    chk("ovl_rsp0", 32'(rsp_valid), 32'h1);
    chk("ovl_no_gnt", 32'(gnt), 32'h0);
    chk("ovl_data", 32'(rsp_data), 32'h7777);
    step();
    chk("ovl_gnt1", 32'(gnt), 32'h2);
    chk("ovl_daddr1", 32'(xadc_daddr), 32'h22);
    chk("ovl_rsp_clr", 32'(rsp_valid), 32'h0);
    req = 2'b00;
    step();
    xadc_drdy = 1'b1; xadc_do = 16'h0001;
    step();
    xadc_drdy = 1'b0;
    chk("ovl_rsp1", 32'(rsp_valid), 32'h2);

    // Reset during WAIT, late drdy, then a tie must favour r0 again.
    req = 2'b01;
    step();
    chk("rw_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    step();
    xadc_reset = 1'b1;
    step();
    xadc_reset = 1'b0;
    chk("rw_busy", 32'(busy), 32'h0);
    chk("rw_rsp", 32'(rsp_valid), 32'h0);
    step();
    xadc_drdy = 1'b1; xadc_do = 16'h9999;
    step();
    xadc_drdy = 1'b0;
    chk("rw_late_rsp", 32'(rsp_valid), 32'h0);
    chk("rw_late_busy", 32'(busy), 32'h0);
    req = 2'b11;
    step();
    chk("rw_tie_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    step();
    xadc_drdy = 1'b1; xadc_do = 16'h0002;
    step();
    xadc_drdy = 1'b0;
    chk("rw_tie_rsp", 32'(rsp_valid), 32'h1);

`ifdef XADC_DRP_ARB_TIMEOUT_EN
    // Timeout after 8 cycles, then a normal transaction.
    req = 2'b01;
    step();
    chk("to_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    for (int c = 1; c < 8; c++) begin
      step();
      chk($sformatf("to_wait%0d", c), 32'({rsp_valid, busy}), 32'h1);
    end
    step();
    chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("to_rsp_err", 32'(rsp_err), 32'h1);
    chk("to_rsp_data", 32'(rsp_data), 32'hFFFF);
    chk("to_busy", 32'(busy), 32'h0);
    req = 2'b10; req_we = 2'b00;
    step();
    chk("to_next_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    step();
    xadc_drdy = 1'b1; xadc_do = 16'hBEEF;
    step();
    xadc_drdy = 1'b0;
    chk("to_next_rsp", 32'(rsp_valid), 32'h2);
    chk("to_next_err", 32'(rsp_err), 32'h0);
    chk("to_next_data", 32'(rsp_data), 32'hBEEF);

    // drdy on the expiry edge wins.
    req = 2'b01;
    step();
    req = 2'b00;
    for (int c = 1; c < 8; c++) step();
    xadc_drdy = 1'b1; xadc_do = 16'h4321;
    step();
    xadc_drdy = 1'b0;
    chk("tie_exp_rsp", 32'(rsp_valid), 32'h1);
    chk("tie_exp_err", 32'(rsp_err), 32'h0);
    chk("tie_exp_data", 32'(rsp_data), 32'h4321);
`else
    // Without the timeout, WAIT persists until drdy.
    req = 2'b01;
    step();
    req = 2'b00;
    for (int c = 1; c < 12; c++) step();
    chk("nt_busy", 32'(busy), 32'h1);
    chk("nt_rsp", 32'(rsp_valid), 32'h0);
    xadc_drdy = 1'b1; xadc_do = 16'h0BAD;
    step();
    xadc_drdy = 1'b0;
    chk("nt_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("nt_rsp_err", 32'(rsp_err), 32'h0);
    chk("nt_rsp_data", 32'(rsp_data), 32'h0BAD);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xadc_drp_arbiter.md
XADC_DRP_ARBITER -- requirements
Module: xadc_drp_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: DRP cycles allowed from den to drdy before abort; valid range 2..65535.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 xadc_dclk  input  1  DRP clock; all logic on rising edge.
REQ-004 xadc_reset  input  1  synchronous active-high reset.
REQ-005 req  input  2  per-requester transaction request (bit0 = sampler, bit1 = config writer); held until matching gnt.
REQ-006 req_we  input  2  per-requester write enable (1 = DRP write, 0 = DRP read).
REQ-007 req_addr  input  14  per-requester DRP address, 7 bits each ([6:0] r0, [13:7] r1).
REQ-008 req_wdata  input  32  per-requester write data, 16 bits each ([15:0] r0, [31:16] r1).
REQ-009 gnt  output  2  one-cycle pulse: request accepted, command captured.
REQ-010 rsp_valid  output  2  one-cycle pulse: transaction complete for that requester.
REQ-011 rsp_data  output  16  DRP read data, valid with rsp_valid; shared by both requesters.
REQ-012 rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-013 busy  output  1  high while a DRP transaction is outstanding.
REQ-014 xadc_daddr  output  7  DRP address.
REQ-015 xadc_den  output  1  DRP enable.
REQ-016 xadc_dwe  output  1  DRP write enable.
REQ-017 xadc_di  output  16  DRP write data.
REQ-018 xadc_do  input  16  DRP read data.
REQ-019 xadc_drdy  input  1  DRP ready.

Function
REQ-020 States: IDLE, WAIT. There is no other state.
REQ-021 IDLE, no req: all pulse outputs are 0 and busy is 0.
REQ-022 IDLE, any req bit set at an edge, on that edge:
- Winner selected.
- gnt[winner] <= 1.
- xadc_den <= 1.
- xadc_dwe, xadc_daddr and xadc_di are loaded from the winner's fields.
- busy <= 1.
- Next state is WAIT.
REQ-023 Arbitration is round-robin: when both request, grant the requester not granted last. The pointer resets so r0 wins the first tie.
REQ-024 xadc_den and gnt are high for exactly one cycle and are cleared on the first WAIT cycle.
REQ-025 xadc_daddr, xadc_dwe and xadc_di hold their values until the next grant.
REQ-026 WAIT with xadc_drdy = 1, on that edge:
- rsp_valid[owner] <= 1.
- rsp_data <= xadc_do; for writes rsp_data <= xadc_do as returned.
- rsp_err <= 0.
- busy <= 0.
- Next state is IDLE.
REQ-027 Latency: req to den is 1 cycle; drdy to rsp_valid is 1 cycle. Minimum spacing between den pulses is 3 cycles, so back-to-back grants are impossible.
REQ-028 req asserted in the cycle drdy returns is not granted until the following IDLE cycle; no request is lost.
REQ-029 xadc_drdy seen in IDLE is ignored and produces no rsp_valid.
REQ-030 Unselected requesters keep req high and receive no gnt; their fields are not sampled.
REQ-031 req_* change while not granted is legal; only the values at the granting edge matter.
REQ-032 rsp_data holds its last value when rsp_valid is low.

Reset
REQ-033 While xadc_reset is high, at each edge:
- State <= IDLE.
- gnt, rsp_valid, rsp_err, busy and xadc_den <= 0.
- xadc_dwe <= 0.
- xadc_daddr, xadc_di and rsp_data <= 0.
- RR pointer <= favour r0.
- Timeout counter <= 0.
REQ-034 Reset during WAIT abandons the transaction with no rsp_valid; a late xadc_drdy after reset is ignored per REQ-029.

Configuration
REQ-035 Macro XADC_DRP_ARB_TIMEOUT_EN defined: a 16-bit counter clears on grant and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without drdy:
- rsp_valid[owner] <= 1.
- rsp_err <= 1.
- rsp_data <= 16'hFFFF.
- busy <= 0.
- Next state is IDLE.
- drdy in the same cycle as expiry wins, with rsp_err = 0.
REQ-036 Macro XADC_DRP_ARB_TIMEOUT_EN undefined: no counter is built, WAIT persists until drdy, and rsp_err is tied 0.

Verification
REQ-037 Sampler-only read: r0 read of 7'h03; drdy 4 cycles after den with do = 16'h1234. Required: gnt = 2'b01 for 1 cycle, den 1 cycle, rsp_valid = 2'b01 with rsp_data = 16'h1234 one cycle after drdy.
REQ-038 Tie: both request continuously for 4 transactions. Required grant order r0, r1, r0, r1; no gnt while busy.
REQ-039 Write: r1 write of 7'h41 with data 16'hA5A5. Required: dwe = 1, daddr = 7'h41, di = 16'hA5A5 with den; rsp_valid = 2'b10.
REQ-040 Timeout (macro on, TIMEOUT_CYCLES = 8): drdy never asserted. Required: rsp_valid, rsp_err = 1 and rsp_data = 16'hFFFF 8 cycles after grant, then the next request is served normally.
REQ-041 Reset in WAIT, then drdy 2 cycles later. Required: no rsp_valid and busy = 0; the next tie grants r0.
REQ-042 drdy and a new r1 req in the same cycle. Required: rsp for the current owner, then gnt[1] exactly 1 cycle later.
